// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter.
//   SEL_*   : codes driven on mux_sel into the existing 4:1 address/wdata mux
//   state_t : arbiter FSM states
package mem_arb_pkg;

    localparam logic [1:0] SEL_IF   = 2'b00;
    localparam logic [1:0] SEL_DATA = 2'b01;
    localparam logic [1:0] SEL_AUX  = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker for the unified memory arbiter.
//   if_req, d_req, aux_req : pending requests
//   starved                : aux has waited STARVE_MAX grants
//   gnt                    : some request is pending
//   owner                  : mux select code of the winner (SEL_IDLE if none)
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  logic       aux_req,
    input  logic       starved,
    output logic       gnt,
    output logic [1:0] owner
);

    always_comb begin
        gnt   = if_req | d_req | aux_req;
        owner = SEL_IDLE;
        if (aux_req && starved)
            owner = SEL_AUX;
        else if (d_req)
            owner = SEL_DATA;   // MEM-stage instruction is older than the fetch
        else if (if_req)
            owner = SEL_IF;
        else if (aux_req)
            owner = SEL_AUX;
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Sequencer for the single-ported unified instruction/data memory.
//   clk, rst_n          : clock, synchronous active-low reset
//   if_req              : fetch request (held until if_ack)
//   d_req, d_we         : load/store request and store flag
//   aux_req, aux_we     : debug/loader request and write flag
//   mux_sel             : 00=IF 01=DATA 10=AUX 11=IDLE
//   mem_en, mem_we      : memory strobes for the current access
//   if_ack/d_ack/aux_ack: one-cycle completion pulses
//   if_stall, mem_stall : pipeline stall lines
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4,
    parameter int CW         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_req,
    input  logic       d_req,
    input  logic       d_we,
    input  logic       aux_req,
    input  logic       aux_we,
    output logic [1:0] mux_sel,
    output logic       mem_en,
    output logic       mem_we,
    output logic       if_ack,
    output logic       d_ack,
    output logic       aux_ack,
    output logic       if_stall,
    output logic       mem_stall
);

    localparam int   BW   = $clog2(MEM_LAT + 1);
    localparam logic LAT1 = (MEM_LAT == 1);

    state_t        state;
    logic [BW-1:0] busy_cnt;
    logic [BW-1:0] cnt_next;
    logic [CW-1:0] starve_cnt;
    logic          starved;
    logic          gnt;
    logic [1:0]    owner;

    assign starved  = (starve_cnt == CW'(STARVE_MAX));
    assign cnt_next = busy_cnt - BW'(1);

    mem_arb_pick u_pick (
        .if_req  (if_req),
        .d_req   (d_req),
        .aux_req (aux_req),
        .starved (starved),
        .gnt     (gnt),
        .owner   (owner)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mux_sel    <= SEL_IDLE;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            aux_ack    <= 1'b0;
            busy_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            // Dropping aux_req clears starvation; a grant below overrides this.
            if (!aux_req)
                starve_cnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (gnt) begin
                        state    <= ST_BUSY;
                        mux_sel  <= owner;
                        mem_en   <= 1'b1;
                        busy_cnt <= BW'(MEM_LAT);
                        mem_we   <= (owner == SEL_DATA) ? d_we :
                                    (owner == SEL_AUX)  ? aux_we : 1'b0;
                        // With single-cycle latency the first BUSY cycle is also the last.
                        if_ack   <= LAT1 && (owner == SEL_IF);
                        d_ack    <= LAT1 && (owner == SEL_DATA);
                        aux_ack  <= LAT1 && (owner == SEL_AUX);
                        if (owner == SEL_AUX)
                            starve_cnt <= '0;
                        else if (aux_req && !starved)
                            starve_cnt <= starve_cnt + CW'(1);
                    end
                end
                ST_BUSY: begin
                    if (busy_cnt == BW'(1)) begin
                        state    <= ST_IDLE;
                        mux_sel  <= SEL_IDLE;
                        mem_en   <= 1'b0;
                        mem_we   <= 1'b0;
                        if_ack   <= 1'b0;
                        d_ack    <= 1'b0;
                        aux_ack  <= 1'b0;
                        busy_cnt <= '0;
                    end else begin
                        busy_cnt <= cnt_next;
                        if_ack   <= (cnt_next == BW'(1)) && (mux_sel == SEL_IF);
                        d_ack    <= (cnt_next == BW'(1)) && (mux_sel == SEL_DATA);
                        aux_ack  <= (cnt_next == BW'(1)) && (mux_sel == SEL_AUX);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter (MEM_LAT=2, STARVE_MAX=4).
// The reference model tracks each access by its start cycle and derives all
// expected outputs from that timestamp.
module tb_unified_mem_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic       clk = 1'b0;
    logic       rst_n, if_req, d_req, d_we, aux_req, aux_we;
    logic [1:0] mux_sel;
    logic       mem_en, mem_we, if_ack, d_ack, aux_ack, if_stall, mem_stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .d_req(d_req), .d_we(d_we),
        .aux_req(aux_req), .aux_we(aux_we),
        .mux_sel(mux_sel), .mem_en(mem_en), .mem_we(mem_we),
        .if_ack(if_ack), .d_ack(d_ack), .aux_ack(aux_ack),
        .if_stall(if_stall), .mem_stall(mem_stall)
    );

    // Reference model: owner 0=IF 1=DATA 2=AUX
    int cyc     = 0;
    bit m_busy  = 0;
    int m_owner = 0;
    int m_start = 0;
    bit m_we    = 0;
    int m_starve = 0;

    // Observation bookkeeping
    bit seen_i, seen_d, seen_a;
    bit hold_d = 0;
    int n_iack = 0, n_dack = 0, n_aack = 0, n_we_hi = 0;
    int iack_cyc = -1, dack_cyc = -1, aack_cyc = -1;

    task automatic check_cycle();
        logic [1:0] e_mux;
        logic e_en, e_we, e_ia, e_da, e_aa, last;
        logic [8:0] exp_v, obs_v;
        e_mux = 2'b11; e_en = 0; e_we = 0; e_ia = 0; e_da = 0; e_aa = 0;
        if (m_busy) begin
            e_mux = (m_owner == 0) ? 2'b00 : (m_owner == 1) ? 2'b01 : 2'b10;
            e_en  = 1;
            e_we  = m_we;
            last  = (cyc == m_start + LAT - 1);
            e_ia  = last && (m_owner == 0);
            e_da  = last && (m_owner == 1);
            e_aa  = last && (m_owner == 2);
        end
        exp_v = {e_mux, e_en, e_we, e_ia, e_da, e_aa, if_req & ~e_ia, d_req & ~e_da};
        obs_v = {mux_sel, mem_en, mem_we, if_ack, d_ack, aux_ack, if_stall, mem_stall};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL outputs cyc=%0d {sel,en,we,ia,da,aa,is,ms} observed=%b expected=%b",
                   cyc, obs_v, exp_v);
        end
        seen_i = if_ack; seen_d = d_ack; seen_a = aux_ack;
        if (if_ack === 1'b1)  begin n_iack++; iack_cyc = cyc; end
        if (d_ack === 1'b1)   begin n_dack++; dack_cyc = cyc; end
        if (aux_ack === 1'b1) begin n_aack++; aack_cyc = cyc; end
        if (mem_we === 1'b1)  n_we_hi++;
    endtask

    task automatic model_update();
        int w;
        if (!rst_n) begin
            m_busy = 0; m_starve = 0;
        end else if (m_busy) begin
            if (cyc == m_start + LAT - 1) m_busy = 0;
            if (!aux_req) m_starve = 0;
        end else begin
            w = -1;
            if (aux_req && m_starve == SMAX) w = 2;
            else if (d_req)   w = 1;
            else if (if_req)  w = 0;
            else if (aux_req) w = 2;
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_start = cyc + 1;
                m_we = (w == 1) ? d_we : (w == 2) ? aux_we : 1'b0;
                if (w == 2)       m_starve = 0;
                else if (aux_req) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
                else              m_starve = 0;
            end else if (!aux_req) m_starve = 0;
        end
    endtask

    // One clock: check mid-cycle, model the edge, then retire acked requests.
    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        if (rst_n) begin
            if (seen_i) if_req = 0;
            if (seen_d && !hold_d) d_req = 0;
            if (seen_a) aux_req = 0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && (m_busy || if_req || d_req || aux_req); k++) tick();
    endtask

    initial begin
        int t0, cnt;
        // Reset with random requests
        rst_n = 0;
        if_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
        aux_req = 1'($urandom); aux_we = 1'($urandom);
        tick();
        tick();
        checks++;
        assert ({mux_sel, mem_en, mem_we, if_ack, d_ack, aux_ack} === 7'b1100000) else begin
            errors++;
            $error("FAIL reset_state observed=%b expected=%b",
                   {mux_sel, mem_en, mem_we, if_ack, d_ack, aux_ack}, 7'b1100000);
        end
        rst_n = 1;
        drain();
        if_req = 0; d_req = 0; aux_req = 0;
        tick();

        // Single fetch
        t0 = cyc; iack_cyc = -1;
        if_req = 1;
        for (int k = 0; k < 10 && iack_cyc < 0; k++) tick();
        checks++;
        assert (iack_cyc === t0 + LAT) else begin
            errors++; $error("FAIL fetch_latency observed=%0d expected=%0d", iack_cyc, t0 + LAT);
        end
        tick();

        // Contention: data before fetch
        t0 = cyc; iack_cyc = -1; dack_cyc = -1;
        if_req = 1; d_req = 1; d_we = 0;
        for (int k = 0; k < 15 && iack_cyc < 0; k++) tick();
        checks++;
        assert (dack_cyc === t0 + LAT) else begin
            errors++; $error("FAIL contention_dack observed=%0d expected=%0d", dack_cyc, t0 + LAT);
        end
        checks++;
        assert (iack_cyc === t0 + 2 * LAT + 1) else begin
            errors++; $error("FAIL contention_iack observed=%0d expected=%0d", iack_cyc, t0 + 2 * LAT + 1);
        end
        tick();

        // Starvation, twice in a row to show the counter restarts from zero
        hold_d = 1; d_req = 1; d_we = 0;
        for (int r = 0; r < 2; r++) begin
            aux_req = 1; aux_we = 1'($urandom);
            cnt = n_dack; aack_cyc = -1;
            for (int k = 0; k < 40 && aack_cyc < 0; k++) tick();
            checks++;
            assert (n_dack - cnt === SMAX) else begin
                errors++; $error("FAIL starve_data_grants round=%0d observed=%0d expected=%0d",
                                 r, n_dack - cnt, SMAX);
            end
            checks++;
            assert (aack_cyc >= 0) else begin
                errors++; $error("FAIL starve_aux_ack round=%0d observed=none expected=pulse", r);
            end
        end
        hold_d = 0; d_req = 0;
        drain();

        // Store: mem_we high on both busy cycles only
        cnt = n_we_hi; dack_cyc = -1;
        d_req = 1; d_we = 1;
        for (int k = 0; k < 10 && dack_cyc < 0; k++) tick();
        tick();
        checks++;
        assert (n_we_hi - cnt === LAT) else begin
            errors++; $error("FAIL store_we_cycles observed=%0d expected=%0d", n_we_hi - cnt, LAT);
        end
        d_we = 0;
        tick();

        // Reset during the first busy cycle of a data access
        t0 = cyc; dack_cyc = -1; cnt = n_dack;
        d_req = 1;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        checks++;
        assert (n_dack === cnt) else begin
            errors++; $error("FAIL midreset_no_ack observed=%0d expected=%0d", n_dack - cnt, 0);
        end
        for (int k = 0; k < 10 && dack_cyc < 0; k++) tick();
        checks++;
        assert (dack_cyc === t0 + 2 * LAT) else begin
            errors++; $error("FAIL midreset_restart observed=%0d expected=%0d", dack_cyc, t0 + 2 * LAT);
        end
        tick();

        // Random traffic honouring the hold-until-ack protocol
        for (int k = 0; k < 500; k++) begin
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 63) == 0) rst_n = 0;
            if (!if_req && $urandom_range(0, 2) == 0) if_req = 1;
            if (!d_req && $urandom_range(0, 2) == 0) begin d_req = 1; d_we = 1'($urandom); end
            if (!aux_req && $urandom_range(0, 4) == 0) begin aux_req = 1; aux_we = 1'($urandom); end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
